// File: rtl/exe_divider.sv
// Multi-cycle radix-2 restoring divider for the EXE stage (DIV/DIVU).
// Holds the pipeline via stallreq_div and delivers quotient/remainder with a one-cycle ready pulse.
module exe_divider #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              div_start,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              flush,
    output logic              stallreq_div,
    output logic              div_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic [1:0]        o_dbg_state
);

    localparam int PW = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [PW-1:0]       r_part;
    logic [DATA_W-1:0]   r_divisor;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_accept;
    logic                w_abort;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [PW-1:0]       w_shift;
    logic [DATA_W+1:0]   w_trial;
    logic [PW-1:0]       w_step;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   w_r;

    assign w_accept = (r_state == S_IDLE) & div_start & ~flush;
    assign w_abort  = flush | ~div_start;

    // Magnitudes for signed operation; 0x80000000 maps onto itself as an unsigned value.
    assign w_abs_a = (div_signed & dividend[DATA_W-1]) ? -dividend : dividend;
    assign w_abs_b = (div_signed & divisor[DATA_W-1])  ? -divisor  : divisor;

    // Lower half carries dividend bits shifting out and quotient bits shifting in.
    assign w_shift = r_part << 1;
    assign w_trial = {1'b0, w_shift[PW-1:DATA_W]} - {2'b00, r_divisor};
    assign w_step  = w_trial[DATA_W+1] ? w_shift
                                       : {w_trial[DATA_W:0], w_shift[DATA_W-1:1], 1'b1};
    assign w_q     = w_step[DATA_W-1:0];
    assign w_r     = w_step[2*DATA_W-1:DATA_W];

    assign stallreq_div = div_start & ~flush & (r_state != S_END);
    assign o_dbg_state  = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (divisor == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                w_next = w_abort ? S_IDLE : S_END;
            end
            S_ON: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_part    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            div_ready <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            r_state   <= w_next;
            div_ready <= (w_next == S_END);
            if (w_accept) begin
                r_part    <= {{(DATA_W+1){1'b0}}, w_abs_a};
                r_divisor <= w_abs_b;
                r_neg_q   <= div_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                r_neg_r   <= div_signed & dividend[DATA_W-1];
                r_cnt     <= '0;
            end else if (r_state == S_ON) begin
                r_part <= w_step;
                r_cnt  <= r_cnt + 1'b1;
            end
            // Results are loaded on the edge into END so they are valid alongside div_ready.
            if (r_state == S_ON && w_next == S_END) begin
                quotient  <= r_neg_q ? -w_q : w_q;
                remainder <= r_neg_r ? -w_r : w_r;
            end else if (r_state == S_BYZERO && w_next == S_END) begin
                quotient  <= '0;
                remainder <= '0;
            end
        end
    end

endmodule

// File: tb/tb_exe_divider.sv
// Bench for exe_divider: directed vector table, flush/abort/reset/back-to-back sequences,
// and random operations checked against an arithmetic reference model.
module tb_exe_divider;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stallreq_div;
    logic        div_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [1:0]  o_dbg_state;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    exe_divider #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .stallreq_div (stallreq_div),
        .div_ready    (div_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / cycle counter
    always #5 cpu_clk_50M = ~cpu_clk_50M;
    always @(posedge cpu_clk_50M) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Issue one op in the next cycle (cycle 0) and hold start until ready or timeout.
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output int stalls, output int rdy_cyc);
        @(posedge cpu_clk_50M); #1;
        div_start  = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        lat = -1; stalls = 0; rdy_cyc = -1; q = '0; r = '0;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            if (k > 0) begin
                @(posedge cpu_clk_50M); #1;
            end
            @(negedge cpu_clk_50M);
            if (stallreq_div) stalls++;
            if (div_ready) begin
                lat     = k;
                q       = quotient;
                r       = remainder;
                rdy_cyc = cyc;
            end
        end
    endtask

    task automatic end_op();
        @(posedge cpu_clk_50M); #1;
        div_start = 1'b0;
    endtask

    task automatic count_ready(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge cpu_clk_50M);
            if (div_ready) seen++;
        end
    endtask

    initial begin
        logic [31:0] q, r;
        logic [63:0] exp;
        int lat, stalls, rc1, rc2, seen;
        logic s;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
        vecs[4] = '{1'b0, 32'd5,          32'd0,          32'h00000000, 32'h00000000, 2};
        vecs[5] = '{1'b1, 32'hFFFFFFF0,   32'd0,          32'h00000000, 32'h00000000, 2};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 33};
        vecs[7] = '{1'b0, 32'd3,          32'd5,          32'h00000000, 32'h00000003, 33};
        vecs[8] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
        vecs[9] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 33};

        // reset
        cpu_rst_n  = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        flush      = 1'b0;
        #12;
        chk("reset_ready", {31'd0, div_ready}, 32'd0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk("reset_state", {30'd0, o_dbg_state}, 32'd0);
        chk("reset_stall", {31'd0, stallreq_div}, 32'd0);
        @(negedge cpu_clk_50M);
        cpu_rst_n = 1'b1;

        // directed vector table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, lat, stalls, rc1);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            if (i == 0) chk("vec0_stall_cycles", 32'(stalls), 32'd33);
            if (i == 4) chk("vec4_stall_cycles", 32'(stalls), 32'd2);
            end_op();
        end

        // back-to-back DIVU ops
        do_op(1'b0, 32'd100, 32'd7, q, r, lat, stalls, rc1);
        chk("b2b_first_q", q, 32'h0000000E);
        do_op(1'b0, 32'hFFFFFFFF, 32'h10, q, r, lat, stalls, rc2);
        chk("b2b_gap", 32'(rc2 - rc1), 32'd34);
        chk("b2b_second_q", q, 32'h0FFFFFFF);
        chk("b2b_second_r", r, 32'h0000000F);
        end_op();

        // flush in cycle 10 of DIVU 100/7
        @(posedge cpu_clk_50M); #1;
        div_start = 1'b1; div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        for (int k = 0; k < 10; k++) begin
            @(posedge cpu_clk_50M); #1;
        end
        flush = 1'b1;
        @(negedge cpu_clk_50M);
        chk("flush_stall_low", {31'd0, stallreq_div}, 32'd0);
        @(posedge cpu_clk_50M); #1;
        flush = 1'b0; div_start = 1'b0;
        @(negedge cpu_clk_50M);
        chk("flush_state_idle", {30'd0, o_dbg_state}, 32'd0);
        count_ready(40, seen);
        chk("flush_no_ready", 32'(seen), 32'd0);
        chk("flush_q_hold", quotient, 32'h0FFFFFFF);
        chk("flush_r_hold", remainder, 32'h0000000F);

        // start dropped mid-ON aborts
        @(posedge cpu_clk_50M); #1;
        div_start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        for (int k = 0; k < 5; k++) begin
            @(posedge cpu_clk_50M); #1;
        end
        div_start = 1'b0;
        count_ready(40, seen);
        chk("abort_no_ready", 32'(seen), 32'd0);
        chk("abort_state_idle", {30'd0, o_dbg_state}, 32'd0);
        chk("abort_q_hold", quotient, 32'h0FFFFFFF);

        // asynchronous reset mid-ON
        @(posedge cpu_clk_50M); #1;
        div_start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        for (int k = 0; k < 6; k++) begin
            @(posedge cpu_clk_50M); #1;
        end
        @(negedge cpu_clk_50M); #2;
        cpu_rst_n = 1'b0;
        #1;
        chk("rst_mid_state", {30'd0, o_dbg_state}, 32'd0);
        chk("rst_mid_q", quotient, 32'd0);
        chk("rst_mid_r", remainder, 32'd0);
        chk("rst_mid_ready", {31'd0, div_ready}, 32'd0);
        div_start = 1'b0;
        @(posedge cpu_clk_50M); #1;
        cpu_rst_n = 1'b1;
        do_op(1'b0, 32'd9, 32'd3, q, r, lat, stalls, rc1);
        chk("post_rst_q", q, 32'd3);
        chk("post_rst_r", r, 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd33);
        end_op();

        // random operations against the model
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2, 3: b = 32'($urandom_range(1, 255));
                4:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            exp = model(s, a, b);
            do_op(s, a, b, q, r, lat, stalls, rc1);
            chk($sformatf("rnd%0d_q", i), q, exp[63:32]);
            chk($sformatf("rnd%0d_r", i), r, exp[31:0]);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), (b == 32'd0) ? 32'd2 : 32'd33);
            if ($urandom_range(0, 1) == 1) end_op();
        end
        end_op();
        repeat (3) @(posedge cpu_clk_50M);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
